// File: rtl/tx_pacer_pkg.sv
// ----------------------------------------------------------------------------
// tx_pacer_pkg
//
// Shared definitions for the TX sample pacer:
//   - pacer_state_t : pacer FSM encoding (IDLE, PRIME, RUN)
//   - field slice constants for the packed 24-bit I/Q word
//     ([23:12] I, [11:0] Q, both two's complement)
//   - SAMPLE_W / WORD_W widths
//   - word_i / word_q helpers that split a packed word into I and Q
// ----------------------------------------------------------------------------
package tx_pacer_pkg;

    // Explicit encodings keep the state register readable in waveforms and
    // stable for any downstream logic that decodes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } pacer_state_t;

    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 2 * SAMPLE_W;

    localparam int I_MSB = 23;
    localparam int I_LSB = 12;
    localparam int Q_MSB = 11;
    localparam int Q_LSB = 0;

    function automatic logic [SAMPLE_W-1:0] word_i(input logic [WORD_W-1:0] w);
        return w[I_MSB:I_LSB];
    endfunction

    function automatic logic [SAMPLE_W-1:0] word_q(input logic [WORD_W-1:0] w);
        return w[Q_MSB:Q_LSB];
    endfunction

endpackage : tx_pacer_pkg

// File: rtl/tx_pacer_fifo.sv
// ----------------------------------------------------------------------------
// tx_pacer_fifo
//
// Single-clock first-word-fall-through FIFO used as the elastic buffer in
// front of the DAC pacer.
//
// Parameters:
//   DEPTH : number of entries, power of two and >= 4 (pointers wrap by
//           natural binary overflow, so a non-power-of-two depth is invalid)
//   WIDTH : word width in bits
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (clears pointers and level;
//                 storage contents are simply abandoned)
//   wr_en    in   write request; ignored while full
//   wr_data  in   write word
//   rd_en    in   pop request; ignored while empty
//   rd_data  out  word at the head of the FIFO (valid whenever !empty)
//   level    out  current occupancy, 0..DEPTH
//   full     out  level == DEPTH
//   empty    out  level == 0
// ----------------------------------------------------------------------------
module tx_pacer_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 24,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_wr;
    logic             do_rd;

    assign full  = (level_reg == FULL_LEVEL);
    assign empty = (level_reg == '0);
    assign level = level_reg;

    // Full is judged on the current level only: a full FIFO refuses a write
    // even in a cycle where it is also being popped.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Head word is presented combinationally so the pacer can capture it in
    // the same edge that commits the pop.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule : tx_pacer_fifo

// File: rtl/tx_sample_pacer.sv
// ----------------------------------------------------------------------------
// tx_sample_pacer
//
// Buffers the 24-bit I/Q AXI-Stream from the TX path in a small FIFO and
// releases one sample to the DAC every div+1 clocks. The FIFO is primed to
// half full before pacing starts; strobes that find the FIFO empty are
// counted as underflows.
//
// Build option:
//   TX_PACER_HOLD_EN  defined   : on underflow dac_i/dac_q keep the last
//                                 popped sample
//                     undefined : on underflow dac_i/dac_q are driven to 0
//   In both builds the DAC outputs are zero outside RUN.
//
// Parameters:
//   DEPTH : FIFO depth in samples (power of two, >= 4)
//   DIV_W : width of the rate divider value
//   CNT_W : width of the underflow counter
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   in_valid       in   AXI-Stream TVALID
//   in_data        in   AXI-Stream TDATA, [23:12] I, [11:0] Q
//   in_ready       out  AXI-Stream TREADY (FIFO not full)
//   enable         in   pacer run enable
//   div            in   strobe period minus one, sampled at each period restart
//   dac_i          out  registered I sample
//   dac_q          out  registered Q sample
//   dac_strobe     out  one-cycle pulse, dac_i/dac_q updated in that cycle
//   underflow_cnt  out  saturating count of strobes that found the FIFO empty
//   fifo_level     out  FIFO occupancy
//   running        out  high while in RUN
// ----------------------------------------------------------------------------
module tx_sample_pacer
    import tx_pacer_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int DIV_W = 8,
    parameter  int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WORD_W-1:0]   in_data,
    output logic                in_ready,
    input  logic                enable,
    input  logic [DIV_W-1:0]    div,
    output logic [SAMPLE_W-1:0] dac_i,
    output logic [SAMPLE_W-1:0] dac_q,
    output logic                dac_strobe,
    output logic [CNT_W-1:0]    underflow_cnt,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                running
);

    localparam logic [LVL_W-1:0] PRIME_LEVEL = LVL_W'(DEPTH / 2);

    pacer_state_t        state_reg;
    pacer_state_t        state_next;
    logic [DIV_W-1:0]    cnt_reg;
    logic [DIV_W-1:0]    div_lat_reg;
    logic [SAMPLE_W-1:0] dac_i_reg;
    logic [SAMPLE_W-1:0] dac_q_reg;
    logic                dac_strobe_reg;
    logic [CNT_W-1:0]    underflow_cnt_reg;

    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_rd_data;
    logic [LVL_W-1:0]    fifo_level_w;

    logic                run_active;
    logic                period_end;
    logic                strobe_evt;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    assign in_ready = !fifo_full;
    assign fifo_wr  = in_valid && !fifo_full;

    tx_pacer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .level   (fifo_level_w),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Strobe generation
    // ------------------------------------------------------------------
    // Dropping enable in RUN suppresses the strobe on the exit edge so no
    // sample is consumed on the way back to IDLE.
    assign run_active = (state_reg == RUN) && enable;
    assign period_end = (cnt_reg == div_lat_reg);
    assign strobe_evt = run_active && period_end;
    assign fifo_rd    = strobe_evt && !fifo_empty;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (fifo_level_w >= PRIME_LEVEL) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // An empty FIFO does not leave RUN; only enable does, and
                // the FIFO contents are kept for the next run.
                if (!enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Rate divider
    // ------------------------------------------------------------------
    // div is captured only when a period restarts; outside RUN the counter
    // sits at 0 and the latch follows div so RUN entry starts with the
    // current value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            div_lat_reg <= '0;
        end else if (run_active) begin
            if (period_end) begin
                cnt_reg     <= '0;
                div_lat_reg <= div;
            end else begin
                cnt_reg     <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg     <= '0;
            div_lat_reg <= div;
        end
    end

    // ------------------------------------------------------------------
    // DAC output registers and underflow counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_i_reg      <= '0;
            dac_q_reg      <= '0;
            dac_strobe_reg <= 1'b0;
        end else begin
            dac_strobe_reg <= strobe_evt;
            if (state_reg != RUN) begin
                dac_i_reg <= '0;
                dac_q_reg <= '0;
            end else if (strobe_evt) begin
                if (!fifo_empty) begin
                    dac_i_reg <= word_i(fifo_rd_data);
                    dac_q_reg <= word_q(fifo_rd_data);
                end else begin
`ifdef TX_PACER_HOLD_EN
                    // Repeat the last sample to avoid a step to mid-scale.
                    dac_i_reg <= dac_i_reg;
                    dac_q_reg <= dac_q_reg;
`else
                    dac_i_reg <= '0;
                    dac_q_reg <= '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_cnt_reg <= '0;
        end else if (strobe_evt && fifo_empty &&
                     (underflow_cnt_reg != {CNT_W{1'b1}})) begin
            underflow_cnt_reg <= underflow_cnt_reg + 1'b1;
        end
    end

    assign dac_i         = dac_i_reg;
    assign dac_q         = dac_q_reg;
    assign dac_strobe    = dac_strobe_reg;
    assign underflow_cnt = underflow_cnt_reg;
    assign fifo_level    = fifo_level_w;
    assign running       = (state_reg == RUN);

endmodule : tx_sample_pacer

// File: tb/tb_tx_sample_pacer.sv
// ----------------------------------------------------------------------------
// tb_tx_sample_pacer
//
// Self-checking bench for tx_sample_pacer. Accepted input words are pushed
// to a scoreboard queue and popped when a DAC strobe is observed. A second
// instance with a 4-bit underflow counter exercises saturation.
// Outputs are sampled on the falling clock edge; inputs change there too.
// ----------------------------------------------------------------------------
module tb_tx_sample_pacer;

    localparam int DEPTH = 16;
    localparam int DIV_W = 8;
    localparam int CNT_W = 16;
    localparam int LVL_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [23:0]       in_data;
    logic              in_ready;
    logic              enable;
    logic [DIV_W-1:0]  div;
    logic [11:0]       dac_i;
    logic [11:0]       dac_q;
    logic              dac_strobe;
    logic [CNT_W-1:0]  underflow_cnt;
    logic [LVL_W-1:0]  fifo_level;
    logic              running;

    logic              in_valid4;
    logic [23:0]       in_data4;
    logic              in_ready4;
    logic              enable4;
    logic [DIV_W-1:0]  div4;
    logic [11:0]       dac_i4;
    logic [11:0]       dac_q4;
    logic              dac_strobe4;
    logic [3:0]        underflow_cnt4;
    logic [LVL_W-1:0]  fifo_level4;
    logic              running4;

    int                total = 0;
    int                bad   = 0;
    logic [23:0]       sbq[$];
    logic [23:0]       last_pop = 24'h0;
    int                uf_exp = 0;

    always #5 clk = ~clk;

    tx_sample_pacer #(.DEPTH(DEPTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_data (in_data),
        .in_ready (in_ready), .enable (enable), .div (div), .dac_i (dac_i),
        .dac_q (dac_q), .dac_strobe (dac_strobe), .underflow_cnt (underflow_cnt),
        .fifo_level (fifo_level), .running (running)
    );

    tx_sample_pacer #(.DEPTH(DEPTH), .DIV_W(DIV_W), .CNT_W(4)) u_dut4 (
        .clk (clk), .rst (rst), .in_valid (in_valid4), .in_data (in_data4),
        .in_ready (in_ready4), .enable (enable4), .div (div4), .dac_i (dac_i4),
        .dac_q (dac_q4), .dac_strobe (dac_strobe4), .underflow_cnt (underflow_cnt4),
        .fifo_level (fifo_level4), .running (running4)
    );

    // Value the DAC should show after a strobe that found the FIFO empty.
    function automatic logic [23:0] uf_word();
`ifdef TX_PACER_HOLD_EN
        return last_pop;
`else
        return 24'h0;
`endif
    endfunction

    // Drive one cycle of stream input (called at a falling edge) and record
    // the word in the scoreboard if it will be accepted on the next edge.
    task automatic tick(input logic v, input logic [23:0] d);
        in_valid = v;
        in_data  = d;
        if (v && in_ready) sbq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0; div = '0;
        in_valid4 = 1'b0; in_data4 = '0; enable4 = 1'b0; div4 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({dac_i, dac_q} !== 24'h0 || dac_strobe !== 1'b0) begin
            bad++; $display("FAIL reset_dac: got %06h/%b want 000000/0", {dac_i, dac_q}, dac_strobe);
        end
        total++;
        if (underflow_cnt !== '0 || fifo_level !== '0 || running !== 1'b0) begin
            bad++; $display("FAIL reset_state: uf=%0d lvl=%0d run=%b want 0/0/0", underflow_cnt, fifo_level, running);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        $display("reset: dac=%06h lvl=%0d ready=%b", {dac_i, dac_q}, fifo_level, in_ready);
    endtask

    task automatic test_rate();
        int pushed = 0;
        int strobes = 0;
        int t = 0;
        int last_t = 0;
        int t_run = -1;
        logic acc;
        logic [23:0] w;
        logic [23:0] exp;
        div = 8'd3; enable = 1'b1;
        while (strobes < 16 && t < 200) begin
            w = {12'(pushed + 1), 12'(pushed + 1)};
            acc = (pushed < 16) && in_ready;
            tick(pushed < 16, w);
            if (acc) pushed++;
            t++;
            if (running && t_run < 0) begin
                t_run = t; total++;
                if (t_run != 9) begin
                    bad++; $display("FAIL rate_prime: RUN entered at cycle %0d want 9", t_run);
                end
            end
            if (dac_strobe) begin
                exp = (sbq.size() > 0) ? sbq.pop_front() : uf_word();
                last_pop = exp;
                total++;
                if ({dac_i, dac_q} !== exp) begin
                    bad++; $display("FAIL rate_data: got %06h want %06h", {dac_i, dac_q}, exp);
                end
                total++;
                if ((strobes == 0 && t != 13) || (strobes > 0 && t - last_t != 4)) begin
                    bad++; $display("FAIL rate_period: strobe %0d at cycle %0d (prev %0d)", strobes, t, last_t);
                end
                $display("rate: strobe %0d cycle %0d dac=%06h", strobes, t, {dac_i, dac_q});
                last_t = t; strobes++;
            end
            total++;
            if (fifo_level !== LVL_W'(sbq.size())) begin
                bad++; $display("FAIL rate_level: got %0d want %0d", fifo_level, sbq.size());
            end
        end
        total++;
        if (strobes != 16 || underflow_cnt !== CNT_W'(uf_exp)) begin
            bad++; $display("FAIL rate_done: strobes=%0d uf=%0d want 16/0", strobes, underflow_cnt);
        end
        enable = 1'b0;
        tick(1'b0, 24'h0);
        tick(1'b0, 24'h0);
        total++;
        if ({dac_i, dac_q} !== 24'h0 || running !== 1'b0) begin
            bad++; $display("FAIL rate_idle: dac=%06h run=%b want 000000/0", {dac_i, dac_q}, running);
        end
    endtask

    task automatic test_underflow();
        int strobes = 0;
        int t = 0;
        int last_t = 0;
        logic [23:0] exp;
        div = 8'd0; enable = 1'b0;
        for (int k = 1; k <= 8; k++) tick(1'b1, {12'(k << 4), 12'hF00 | 12'(k)});
        enable = 1'b1;
        while (strobes < 14 && t < 60) begin
            tick(1'b0, 24'h0);
            t++;
            if (dac_strobe) begin
                if (sbq.size() > 0) begin
                    exp = sbq.pop_front(); last_pop = exp;
                end else begin
                    exp = uf_word(); uf_exp++;
                end
                total++;
                if ({dac_i, dac_q} !== exp) begin
                    bad++; $display("FAIL uf_data: strobe %0d got %06h want %06h", strobes, {dac_i, dac_q}, exp);
                end
                total++;
                if (underflow_cnt !== CNT_W'(uf_exp)) begin
                    bad++; $display("FAIL uf_count: strobe %0d got %0d want %0d", strobes, underflow_cnt, uf_exp);
                end
                total++;
                if (strobes > 0 && t - last_t != 1) begin
                    bad++; $display("FAIL uf_period: strobe %0d gap %0d want 1", strobes, t - last_t);
                end
                $display("underflow: strobe %0d dac=%06h uf=%0d", strobes, {dac_i, dac_q}, underflow_cnt);
                last_t = t; strobes++;
            end
        end
        total++;
        if (strobes != 14) begin
            bad++; $display("FAIL uf_timeout: saw %0d strobes want 14", strobes);
        end
        enable = 1'b0;
        tick(1'b0, 24'h0);
        tick(1'b0, 24'h0);
        total++;
        if ({dac_i, dac_q} !== 24'h0) begin
            bad++; $display("FAIL uf_idle_zero: got %06h want 000000", {dac_i, dac_q});
        end
    endtask

    task automatic test_full();
        logic saw_strobe = 1'b0;
        enable = 1'b0; div = 8'd2;
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, {12'(12'h040 + i), 12'(12'h800 | i)});
            if (dac_strobe) saw_strobe = 1'b1;
        end
        total++;
        if (in_ready !== 1'b0 || fifo_level !== LVL_W'(DEPTH) || sbq.size() != DEPTH) begin
            bad++; $display("FAIL full_level: ready=%b lvl=%0d model=%0d want 0/16", in_ready, fifo_level, sbq.size());
        end
        total++;
        if (saw_strobe || {dac_i, dac_q} !== 24'h0 || running !== 1'b0) begin
            bad++; $display("FAIL full_idle: strobe=%b dac=%06h run=%b want 0/000000/0", saw_strobe, {dac_i, dac_q}, running);
        end
        tick(1'b0, 24'h0);
        $display("full: lvl=%0d ready=%b", fifo_level, in_ready);
    endtask

    task automatic test_div_change();
        int exp_gap[5] = '{0, 3, 3, 6, 6};
        int strobes = 0;
        int t = 0;
        int last_t = 0;
        logic [23:0] exp;
        div = 8'd2; enable = 1'b1;
        while (strobes < 5 && t < 80) begin
            tick(1'b0, 24'h0);
            t++;
            if (dac_strobe) begin
                exp = (sbq.size() > 0) ? sbq.pop_front() : uf_word();
                last_pop = exp;
                total++;
                if ({dac_i, dac_q} !== exp) begin
                    bad++; $display("FAIL div_data: got %06h want %06h", {dac_i, dac_q}, exp);
                end
                total++;
                if (strobes > 0 && t - last_t != exp_gap[strobes]) begin
                    bad++; $display("FAIL div_period: strobe %0d gap %0d want %0d", strobes, t - last_t, exp_gap[strobes]);
                end
                $display("div_change: strobe %0d gap %0d", strobes, t - last_t);
                last_t = t; strobes++;
                if (strobes == 2) div = 8'd5;
            end
        end
        enable = 1'b0;
        tick(1'b0, 24'h0);
        tick(1'b0, 24'h0);
        total++;
        if (strobes != 5 || fifo_level !== 5'd11 || sbq.size() != 11) begin
            bad++; $display("FAIL div_retain: strobes=%0d lvl=%0d model=%0d want 5/11", strobes, fifo_level, sbq.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int t = 0;
        logic [23:0] exp;
        div = 8'd1; enable = 1'b1;
        while (sbq.size() > 5 && t < 60) begin
            tick(1'b0, 24'h0);
            t++;
            if (dac_strobe) begin
                exp = (sbq.size() > 0) ? sbq.pop_front() : uf_word();
                last_pop = exp;
                total++;
                if ({dac_i, dac_q} !== exp) begin
                    bad++; $display("FAIL mid_data: got %06h want %06h", {dac_i, dac_q}, exp);
                end
            end
        end
        total++;
        if (running !== 1'b1 || fifo_level !== 5'd5) begin
            bad++; $display("FAIL mid_setup: run=%b lvl=%0d want 1/5", running, fifo_level);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({dac_i, dac_q} !== 24'h0 || dac_strobe !== 1'b0 || underflow_cnt !== '0) begin
            bad++; $display("FAIL mid_rst_out: dac=%06h stb=%b uf=%0d want 0", {dac_i, dac_q}, dac_strobe, underflow_cnt);
        end
        total++;
        if (fifo_level !== '0 || running !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_rst_state: lvl=%0d run=%b ready=%b want 0/0/1", fifo_level, running, in_ready);
        end
        sbq.delete(); uf_exp = 0; last_pop = 24'h0; enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (fifo_level !== '0 || dac_strobe !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_release: lvl=%0d stb=%b ready=%b want 0/0/1", fifo_level, dac_strobe, in_ready);
        end
        $display("reset_mid_run: lvl=%0d run=%b", fifo_level, running);
    endtask

    task automatic test_saturation();
        int strobes = 0;
        int uf = 0;
        int t = 0;
        int exp;
        div4 = 8'd0; enable4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid4 = 1'b1; in_data4 = {12'(k), 12'(k)};
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        enable4 = 1'b1;
        while (strobes < 28 && t < 80) begin
            @(negedge clk);
            t++;
            if (dac_strobe4) begin
                strobes++;
                if (strobes > 8) uf++;
                exp = (uf > 15) ? 15 : uf;
                total++;
                if (underflow_cnt4 !== 4'(exp)) begin
                    bad++; $display("FAIL sat_count: strobe %0d got %0d want %0d", strobes, underflow_cnt4, exp);
                end
            end
        end
        total++;
        if (strobes != 28 || underflow_cnt4 !== 4'd15) begin
            bad++; $display("FAIL sat_final: strobes=%0d uf=%0d want 28/15", strobes, underflow_cnt4);
        end
        $display("saturation: strobes=%0d uf=%0d", strobes, underflow_cnt4);
        enable4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rate();
        test_underflow();
        test_full();
        test_div_change();
        test_reset_mid_run();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_tx_sample_pacer
